port_link_host: RTL and testbench

PORT_LINK_HOST -- requirements
Module: port_link_host

---
 rtl/port_link_host.sv | 195 +++++++++++++++++++
 tb/tb_port_link_host.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_link_host.sv
`timescale 1ns/1ps
// Host side of a byte-wide strobe/acknowledge link to an MCU: a 4-entry TX FIFO drives P2/P3 STB,
// and an independent RX path captures P0 and answers the MCU strobe with P3 ACK.
module port_link_host #(
    parameter int unsigned SETUP   = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_err,
    input  logic       err_clr,
    output logic [7:0] p2_out,
    output logic [7:0] p3_out,
    input  logic [7:0] p0_in,
    input  logic [3:0] p1l_in
);

    localparam logic [15:0] SETUP_LAST   = 16'(SETUP - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_STROBE, TX_RELEASE} tx_state_t;
    typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;

    logic [1:0] stb_sync, ack_sync;
    logic       mcu_stb, mcu_ack;
    logic [1:0] unused_p1l;

    assign unused_p1l = p1l_in[3:2];

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            stb_sync <= '0;
            ack_sync <= '0;
        end else begin
            stb_sync <= {stb_sync[0], p1l_in[0]};
            ack_sync <= {ack_sync[0], p1l_in[1]};
        end
    end

    assign mcu_stb = stb_sync[1];
    assign mcu_ack = ack_sync[1];

    // TX FIFO
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count, count_next;
    logic       push, pop;

    assign push       = wr_en && !full;
    assign count_next = count + 3'(push) - 3'(pop);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count_next;
            full  <= (count_next == 3'd4);
        end
    end

    // NOTE: storage has no reset; emptiness is defined by count, so stale entries are never read.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= wr_data;
    end

    // TX handshake
    tx_state_t   tx_state, tx_next;
    logic [15:0] wait_cnt, cnt_next;
    logic [7:0]  p2_next;
    logic        host_stb, stb_next;
    logic        err_set;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tx_next  = tx_state;
        cnt_next = wait_cnt + 16'd1;
        p2_next  = p2_out;
        stb_next = host_stb;
        pop      = 1'b0;
        err_set  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                cnt_next = '0;
                if (count != 3'd0) begin
                    p2_next = fifo_mem[rd_ptr];
                    tx_next = TX_SETUP;
                end
            end
            TX_SETUP: begin
                if (wait_cnt == SETUP_LAST) begin
                    stb_next = 1'b1;
                    cnt_next = '0;
                    tx_next  = TX_STROBE;
                end
            end
            TX_STROBE: begin
                if (mcu_ack) begin
                    stb_next = 1'b0;
                    cnt_next = '0;
                    tx_next  = TX_RELEASE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    stb_next = 1'b0;
                    pop      = 1'b1;
                    err_set  = 1'b1;
                    cnt_next = '0;
                    tx_next  = TX_IDLE;
                end
            end
            TX_RELEASE: begin
                // A stuck-high ACK times out exactly like a missing one.
                if (!mcu_ack || wait_cnt == TIMEOUT_LAST) begin
                    pop      = 1'b1;
                    err_set  = mcu_ack;
                    cnt_next = '0;
                    tx_next  = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            wait_cnt <= '0;
            p2_out   <= '0;
            host_stb <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            wait_cnt <= cnt_next;
            p2_out   <= p2_next;
            host_stb <= stb_next;
            if (err_set)      tx_err <= 1'b1;
            else if (err_clr) tx_err <= 1'b0;
        end
    end

    // RX handshake
    rx_state_t  rx_state, rx_next;
    logic [7:0] rx_data_next;
    logic       rx_valid_next, host_ack, ack_next;

    always_comb begin
        rx_next       = rx_state;
        rx_data_next  = rx_data;
        rx_valid_next = 1'b0;
        ack_next      = host_ack;
        case (rx_state)
            RX_IDLE: begin
                if (mcu_stb) begin
                    rx_data_next  = p0_in;
                    rx_valid_next = 1'b1;
                    ack_next      = 1'b1;
                    rx_next       = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!mcu_stb) begin
                    ack_next = 1'b0;
                    rx_next  = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rx_state <= RX_IDLE;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            host_ack <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_data  <= rx_data_next;
            rx_valid <= rx_valid_next;
            host_ack <= ack_next;
        end
    end

    assign p3_out = {6'b000000, host_ack, host_stb};

endmodule

// File: tb/tb_port_link_host.sv
`timescale 1ns/1ps
// Self-checking bench for port_link_host: a protocol-level model compared every cycle,
// an MCU responder with a byte scoreboard, and directed scenarios with literal expectations.
module tb_port_link_host;

    localparam int SETUP_C   = 2;
    localparam int TIMEOUT_C = 8;

    logic       CLK = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_err;
    logic       err_clr = 1'b0;
    logic [7:0] p2_out;
    logic [7:0] p3_out;
    logic [7:0] p0_in = '0;
    logic [3:0] p1l_in;
    logic       mcu_stb = 1'b0;
    logic       mcu_ack = 1'b0;
    logic       mcu_ack_en = 1'b0;
    logic [1:0] p1_junk = 2'b10;

    assign p1l_in = {p1_junk, mcu_ack, mcu_stb};

    port_link_host #(.SETUP(SETUP_C), .TIMEOUT(TIMEOUT_C)) dut (
        .CLK     (CLK),
        .resetn  (resetn),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_err  (tx_err),
        .err_clr (err_clr),
        .p2_out  (p2_out),
        .p3_out  (p3_out),
        .p0_in   (p0_in),
        .p1l_in  (p1l_in)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: the TX byte is offered, held SETUP cycles, strobed until the
    // (2-cycle delayed) ACK is seen, then released until ACK is seen low; each wait gives up
    // after TIMEOUT cycles. RX outputs are the MCU strobe delayed through the synchronizer.
    typedef enum {M_WAIT_DATA, M_HOLD_DATA, M_STB_HIGH, M_ACK_DOWN} m_phase_t;
    m_phase_t   m_ph = M_WAIT_DATA;
    int         m_cnt = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_p2 = '0;
    logic       m_stb = 1'b0, m_full = 1'b0, m_err = 1'b0;
    logic       m_ack = 1'b0, m_valid = 1'b0;
    logic [7:0] m_rxd = '0;
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, a1 = 1'b0, a2 = 1'b0;

    task automatic model_reset();
        m_ph = M_WAIT_DATA; m_cnt = 0; m_q.delete();
        m_p2 = '0; m_stb = 1'b0; m_full = 1'b0; m_err = 1'b0;
        m_ack = 1'b0; m_valid = 1'b0; m_rxd = '0;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    endtask

    task automatic model_step();
        logic drop, err_now, accept;
        drop = 1'b0;
        err_now = 1'b0;
        case (m_ph)
            M_WAIT_DATA: if (m_q.size() != 0) begin m_p2 = m_q[0]; m_ph = M_HOLD_DATA; m_cnt = 1; end
            M_HOLD_DATA: if (m_cnt == SETUP_C) begin m_stb = 1'b1; m_ph = M_STB_HIGH; m_cnt = 1; end
                         else m_cnt++;
            M_STB_HIGH: if (a2) begin m_stb = 1'b0; m_ph = M_ACK_DOWN; m_cnt = 1; end
                        else if (m_cnt == TIMEOUT_C) begin m_stb = 1'b0; drop = 1'b1; err_now = 1'b1; m_ph = M_WAIT_DATA; end
                        else m_cnt++;
            M_ACK_DOWN: if (!a2) begin drop = 1'b1; m_ph = M_WAIT_DATA; end
                        else if (m_cnt == TIMEOUT_C) begin drop = 1'b1; err_now = 1'b1; m_ph = M_WAIT_DATA; end
                        else m_cnt++;
            default: m_ph = M_WAIT_DATA;
        endcase
        accept = wr_en && (m_q.size() < 4);
        if (drop) void'(m_q.pop_front());
        if (accept) m_q.push_back(wr_data);
        m_full = (m_q.size() == 4);
        if (err_now) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_ack   = s2;
        m_valid = s2 & ~s3;
        if (m_valid) m_rxd = p0_in;
        s3 = s2; s2 = s1; s1 = p1l_in[0];
        a2 = a1; a1 = p1l_in[1];
    endtask

    initial forever begin
        @(posedge CLK or negedge resetn);
        if (!resetn) model_reset();
        else model_step();
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge CLK);
        if (resetn) begin
            check("p2_out", p2_out, m_p2);
            check("p3_out", p3_out, {6'b000000, m_ack, m_stb});
            check("full", full, m_full);
            check("tx_err", tx_err, m_err);
            check("rx_valid", rx_valid, m_valid);
            check("rx_data", rx_data, m_rxd);
        end
    end

    // MCU responder: acknowledges host strobes and scores each received byte.
    logic [7:0] exp_tx[$];
    logic [7:0] exp_b;
    int         tx_got = 0;

    initial forever begin
        @(negedge CLK);
        if (!resetn) begin
            mcu_ack = 1'b0;
        end else if (mcu_ack_en && p3_out[0] && !mcu_ack) begin
            if (exp_tx.size() != 0) exp_b = exp_tx.pop_front();
            else exp_b = 8'hxx;
            check("tx_byte", p2_out, exp_b);
            tx_got++;
            mcu_ack = 1'b1;
        end else if (!p3_out[0] && mcu_ack) begin
            mcu_ack = 1'b0;
        end
    end

    // Event monitor for timing measurements.
    int   cyc = 0;
    int   stb_rise_cyc = 0, stb_len = 0, p2_chg_cyc = 0, stb_rises = 0;
    int   rx_cnt = 0, ack_hi = 0, err_hi = 0;
    logic prev_stb = 1'b0;
    logic [7:0] prev_p2 = '0;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(negedge CLK);
        if (p3_out[0] && !prev_stb) begin stb_rise_cyc = cyc; stb_rises++; end
        if (!p3_out[0] && prev_stb) stb_len = cyc - stb_rise_cyc;
        if (p2_out != prev_p2) p2_chg_cyc = cyc;
        if (rx_valid) rx_cnt++;
        if (p3_out[1]) ack_hi++;
        if (tx_err) err_hi++;
        prev_stb = p3_out[0];
        prev_p2  = p2_out;
    end

    task automatic push_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge CLK);
        wr_en   = 1'b0;
    endtask

    task automatic wait_tx_idle(input int budget, input string name);
        int n = 0;
        while (!(m_ph == M_WAIT_DATA && m_q.size() == 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, (n < budget), 1'b1);
    endtask

    task automatic wait_stb(input logic level, input int budget, input string name);
        int n = 0;
        while (p3_out[0] !== level && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, (n < budget), 1'b1);
    endtask

    initial begin : main
        int base_tx, base_rx, base_ack, base_err, base_rises;

        #1 resetn = 1'b0;
        #1;
        check("rst_p2_out", p2_out, 8'h00);
        check("rst_p3_out", p3_out, 8'h00);
        check("rst_full", full, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_err", tx_err, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);

        // Single byte with a cooperating MCU.
        mcu_ack_en = 1'b1;
        exp_tx.push_back(8'hA5);
        push_byte(8'hA5);
        wait_tx_idle(60, "a5_done");
        check("a5_setup_lead", stb_rise_cyc - p2_chg_cyc, 2);
        check("a5_sent", tx_got, 1);
        check("a5_pending", exp_tx.size(), 0);
        check("a5_not_full", full, 1'b0);

        // Overfill while the MCU is silent, then let it drain.
        mcu_ack_en = 1'b0;
        base_tx = tx_got;
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            @(negedge CLK);
            if (i == 4) check("full_after_4", full, 1'b1);
        end
        wr_en = 1'b0;
        check("full_after_5", full, 1'b1);
        for (int i = 1; i <= 4; i++) exp_tx.push_back(8'(i));
        mcu_ack_en = 1'b1;
        wait_tx_idle(300, "burst_done");
        check("burst_count", tx_got - base_tx, 4);
        check("burst_pending", exp_tx.size(), 0);
        check("burst_no_err", tx_err, 1'b0);

        // MCU never acknowledges: timeout drops the byte.
        mcu_ack_en = 1'b0;
        base_tx = tx_got;
        push_byte(8'h3C);
        wait_stb(1'b1, 20, "to_stb_rise");
        wait_stb(1'b0, 20, "to_stb_fall");
        check("to_stb_cycles", stb_len, 8);
        check("to_err_set", tx_err, 1'b1);
        wait_tx_idle(20, "to_done");
        check("to_dropped", tx_got - base_tx, 0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("err_cleared", tx_err, 1'b0);

        // Timeout while err_clr is held: the error must still be recorded.
        err_clr  = 1'b1;
        base_err = err_hi;
        push_byte(8'h3C);
        wait_tx_idle(40, "toclr_done");
        @(negedge CLK);
        err_clr = 1'b0;
        check("err_clr_collide", err_hi - base_err, 1);

        // MCU strobe held for 20 cycles.
        base_rx  = rx_cnt;
        base_ack = ack_hi;
        p0_in    = 8'h5A;
        mcu_stb  = 1'b1;
        repeat (20) @(negedge CLK);
        check("rx_ack_held", p3_out[1], 1'b1);
        mcu_stb = 1'b0;
        p0_in   = 8'h00;
        repeat (5) @(negedge CLK);
        check("rx_one_pulse", rx_cnt - base_rx, 1);
        check("rx_data_5a", rx_data, 8'h5A);
        check("rx_ack_len", ack_hi - base_ack, 20);
        check("rx_ack_low", p3_out[1], 1'b0);

        // TX and RX at the same time.
        mcu_ack_en = 1'b1;
        base_tx = tx_got;
        base_rx = rx_cnt;
        exp_tx.push_back(8'h11);
        p0_in   = 8'h22;
        mcu_stb = 1'b1;
        push_byte(8'h11);
        repeat (9) @(negedge CLK);
        mcu_stb = 1'b0;
        wait_tx_idle(60, "conc_tx_done");
        repeat (4) @(negedge CLK);
        check("conc_tx_count", tx_got - base_tx, 1);
        check("conc_pending", exp_tx.size(), 0);
        check("conc_rx_count", rx_cnt - base_rx, 1);
        check("conc_rx_data", rx_data, 8'h22);

        // Reset during STROBE with a full FIFO and an MCU strobe in flight.
        mcu_ack_en = 1'b0;
        p0_in = 8'h77;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hAA + 8'(i * 17);
            wr_en   = 1'b1;
            @(negedge CLK);
        end
        wr_en = 1'b0;
        wait_stb(1'b1, 20, "rst_in_strobe");
        check("rst_pre_full", full, 1'b1);
        base_rx = rx_cnt;
        mcu_stb = 1'b1;
        @(posedge CLK);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_p3", p3_out, 8'h00);
        check("rst_async_full", full, 1'b0);
        check("rst_async_p2", p2_out, 8'h00);
        mcu_stb = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
        base_rises = stb_rises;
        repeat (20) @(negedge CLK);
        check("rst_no_tx", stb_rises - base_rises, 0);
        check("rst_no_rx", rx_cnt - base_rx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
